sa_main: RTL and testbench

SA_MAIN -- requirements
Module: sa_main

---
 rtl/sa_main_pkg.sv | 18 +
 rtl/sa_main_rr_arb.sv | 33 +++
 rtl/sa_main.sv | 117 +++++++++++
 tb/tb_sa_main.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_main_pkg.sv
// Shared constants and types for the sa_main switch allocator: port count,
// datapath width, per-output state encoding and a pointer-wrap helper.
package sa_main_pkg;

    localparam int N_PORTS = 5;
    localparam int DW      = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

    // Round-robin pointer advance with wrap from n-1 back to 0.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/sa_main_rr_arb.sv
// N-way round-robin priority arbiter: grants the first requester at or after
// i_ptr, scanning upward modulo N. Purely combinational.
module rr_arb
    import sa_main_pkg::*;
#(
    parameter int N  = N_PORTS,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    int   w_idx;
    logic w_found;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && i_req[w_idx[PW-1:0]]) begin
                o_grant[w_idx[PW-1:0]] = 1'b1;
                w_found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_main.sv
// Switch allocator: one round-robin arbiter per output port driving crossbar
// selects and input grants. Define SA_WORMHOLE_LOCK_EN for packet-level locking.
module sa_main
    import sa_main_pkg::*;
#(
    parameter int N = N_PORTS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N*N-1:0]   req_from_P,
    input  logic [N-1:0]     tail_from_P,
    input  logic [N-1:0]     ready_of_OP,
    output logic [N*N-1:0]   sel_for_OP,
    output logic [N-1:0]     grant_to_P
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  w_req_col  [N];
    logic [N-1:0]  w_arb_gnt  [N];
    logic [N-1:0]  w_sel      [N];
    logic [PW-1:0] w_win_idx  [N];
    logic [PW-1:0] w_ptr_next [N];
    logic [N-1:0]  w_fire;
    logic [PW-1:0] r_ptr      [N];

    // Regroup requests by output: w_req_col[o][i] is input i asking for output o.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                w_req_col[o][i] = req_from_P[i*N + o];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_arb
        rr_arb #(.N(N), .PW(PW)) u_rr_arb (
            .i_req   (w_req_col[g]),
            .i_ptr   (r_ptr[g]),
            .o_grant (w_arb_gnt[g])
        );
    end

`ifdef SA_WORMHOLE_LOCK_EN
    out_state_e    r_state [N];
    logic [PW-1:0] r_owner [N];
    logic [N-1:0]  w_tail_hit;

    always_comb begin
        for (int o = 0; o < N; o++) begin
            w_sel[o] = (r_state[o] == ST_LOCKED)
                     ? ({{(N-1){1'b0}}, 1'b1} << r_owner[o])
                     : w_arb_gnt[o];
            if (!rstn) w_sel[o] = '0;
            w_tail_hit[o] = |(w_sel[o] & tail_from_P);
        end
    end
`else
    always_comb begin
        for (int o = 0; o < N; o++) begin
            w_sel[o] = rstn ? w_arb_gnt[o] : '0;
        end
    end
`endif

    // A locked output whose owner is not requesting (bubble) keeps its select
    // but must not fire, hence the AND with the request column.
    always_comb begin
        grant_to_P = '0;
        sel_for_OP = '0;
        for (int o = 0; o < N; o++) begin
            w_fire[o]     = ready_of_OP[o] & (|(w_sel[o] & w_req_col[o]));
            w_win_idx[o]  = '0;
            for (int i = 0; i < N; i++) begin
                if (w_sel[o][i]) w_win_idx[o] = PW'(i);
            end
            w_ptr_next[o] = PW'(wrap_inc(int'(w_win_idx[o]), N));
            sel_for_OP[o*N +: N] = w_sel[o];
            if (w_fire[o]) grant_to_P = grant_to_P | w_sel[o];
        end
    end

    // NOTE: state registers use non-blocking assignments so every output
    // updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int o = 0; o < N; o++) begin
                r_ptr[o] <= '0;
`ifdef SA_WORMHOLE_LOCK_EN
                r_state[o] <= ST_IDLE;
                r_owner[o] <= '0;
`endif
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                if (w_fire[o]) begin
`ifdef SA_WORMHOLE_LOCK_EN
                    if (r_state[o] == ST_IDLE) begin
                        if (w_tail_hit[o]) begin
                            r_ptr[o] <= w_ptr_next[o];
                        end else begin
                            r_state[o] <= ST_LOCKED;
                            r_owner[o] <= w_win_idx[o];
                        end
                    end else if (w_tail_hit[o]) begin
                        r_state[o] <= ST_IDLE;
                        r_ptr[o]   <= w_ptr_next[o];
                    end
`else
                    r_ptr[o] <= w_ptr_next[o];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_main.sv
// Self-checking bench for sa_main: directed scenarios then random traffic,
// compared every cycle against a per-output behavioural arbitration model.
module tb_sa_main;

    localparam int NP = 5;
`ifdef SA_WORMHOLE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic             clk;
    logic             rstn;
    logic [NP*NP-1:0] req_from_P;
    logic [NP-1:0]    tail_from_P;
    logic [NP-1:0]    ready_of_OP;
    logic [NP*NP-1:0] sel_for_OP;
    logic [NP-1:0]    grant_to_P;

    sa_main #(.N(NP)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_from_P  (req_from_P),
        .tail_from_P (tail_from_P),
        .ready_of_OP (ready_of_OP),
        .sel_for_OP  (sel_for_OP),
        .grant_to_P  (grant_to_P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus: destination output per input (-1 = idle), tails, readiness.
    int          g_dest [NP];
    logic [NP-1:0] g_tail;
    logic [NP-1:0] g_ready;
    logic        g_rstn;

    // Reference model state, per output.
    int m_ptr   [NP];
    bit m_lock  [NP];
    int m_owner [NP];

    logic [NP-1:0] last_grant;
    logic [NP-1:0] last_sel [NP];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NP; i++) g_dest[i] = -1;
        g_tail  = '0;
        g_ready = '1;
        g_rstn  = 1'b1;
    endtask

    // One clock cycle: apply inputs, compare combinational outputs against the
    // model, then advance the model across the rising edge.
    task automatic step(input string tag);
        logic [NP-1:0] e_sel [NP];
        logic [NP-1:0] e_grant;
        int            e_win [NP];
        bit            e_fire[NP];
        int            i;
        req_from_P = '0;
        for (int p = 0; p < NP; p++)
            if (g_dest[p] >= 0) req_from_P[p*NP + g_dest[p]] = 1'b1;
        tail_from_P = g_tail;
        ready_of_OP = g_ready;
        rstn        = g_rstn;
        #2;
        e_grant = '0;
        for (int o = 0; o < NP; o++) begin
            e_win[o]  = -1;
            e_fire[o] = 1'b0;
            e_sel[o]  = '0;
            if (!g_rstn) continue;
            if (m_lock[o]) begin
                e_win[o]  = m_owner[o];
                e_fire[o] = g_ready[o] && (g_dest[m_owner[o]] == o);
            end else begin
                for (int k = 0; k < NP; k++) begin
                    i = (m_ptr[o] + k) % NP;
                    if (g_dest[i] == o) begin
                        e_win[o] = i;
                        break;
                    end
                end
                e_fire[o] = g_ready[o] && (e_win[o] >= 0);
            end
            if (e_win[o] >= 0) e_sel[o][e_win[o]] = 1'b1;
            if (e_fire[o]) e_grant[e_win[o]] = 1'b1;
        end
        for (int o = 0; o < NP; o++) begin
            last_sel[o] = sel_for_OP[o*NP +: NP];
            check($sformatf("%s_sel%0d", tag, o), 32'(last_sel[o]), 32'(e_sel[o]));
        end
        last_grant = grant_to_P;
        check($sformatf("%s_grant", tag), 32'(last_grant), 32'(e_grant));
        @(posedge clk);
        for (int o = 0; o < NP; o++) begin
            if (!g_rstn) begin
                m_ptr[o] = 0; m_lock[o] = 1'b0; m_owner[o] = 0;
            end else if (e_fire[o]) begin
                if (!LOCK) begin
                    m_ptr[o] = (e_win[o] + 1) % NP;
                end else if (!m_lock[o]) begin
                    if (g_tail[e_win[o]]) m_ptr[o] = (e_win[o] + 1) % NP;
                    else begin m_lock[o] = 1'b1; m_owner[o] = e_win[o]; end
                end else if (g_tail[e_win[o]]) begin
                    m_lock[o] = 1'b0;
                    m_ptr[o]  = (e_win[o] + 1) % NP;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        g_rstn = 1'b0;
        step("rst");
        clear_inputs();
    endtask

    initial begin
        for (int o = 0; o < NP; o++) begin
            m_ptr[o] = 0; m_lock[o] = 1'b0; m_owner[o] = 0;
        end
        clear_inputs();
        @(negedge clk);

        // Reset with every input requesting: outputs must be silent.
        for (int i = 0; i < NP; i++) g_dest[i] = i;
        g_tail = '1; g_rstn = 1'b0;
        step("in_rst");
        check("in_rst_sel_all", 32'(sel_for_OP), 32'd0);

        // Inputs 0,2,4 to output 1 with tails: round-robin order P0,P2,P4.
        clear_inputs();
        g_dest[0] = 1; g_dest[2] = 1; g_dest[4] = 1; g_tail = '1;
        step("rr_c0"); check("rr_g0", 32'(last_grant), 32'h01);
        g_dest[0] = -1;
        step("rr_c1"); check("rr_g1", 32'(last_grant), 32'h04);
        g_dest[2] = -1;
        step("rr_c2"); check("rr_g2", 32'(last_grant), 32'h10);
        // Pointer back at 0: P0 beats P4 again.
        g_dest[0] = 1; g_dest[4] = 1;
        step("rr_wrap"); check("rr_wrap_g", 32'(last_grant), 32'h01);

`ifdef SA_WORMHOLE_LOCK_EN
        // P1 sends a 4-flit packet to OP3; P0 contends from the second flit.
        do_reset();
        g_dest[1] = 3;
        step("lk_h"); check("lk_h_sel", 32'(last_sel[3]), 32'h02);
        g_dest[0] = 3;
        step("lk_b1"); check("lk_b1_sel", 32'(last_sel[3]), 32'h02);
        step("lk_b2"); check("lk_b2_sel", 32'(last_sel[3]), 32'h02);
        g_tail[1] = 1'b1;
        step("lk_t"); check("lk_t_sel", 32'(last_sel[3]), 32'h02);
        g_dest[1] = -1; g_tail = '0;
        step("lk_p0"); check("lk_p0_g", 32'(last_grant), 32'h01);
        // Bubble while locked: owner P0 silent, P2 requesting, nothing granted.
        g_dest[0] = -1; g_dest[2] = 3;
        step("lk_bub"); check("lk_bub_g", 32'(last_grant), 32'h00);
`else
        // Without locking, non-tail flits still alternate P1, P0, P1, P0.
        do_reset();
        g_dest[0] = 3;
        step("nl_pre");
        g_dest[1] = 3;
        step("nl_a0"); check("nl_a0_g", 32'(last_grant), 32'h02);
        step("nl_a1"); check("nl_a1_g", 32'(last_grant), 32'h01);
        step("nl_a2"); check("nl_a2_g", 32'(last_grant), 32'h02);
        step("nl_a3"); check("nl_a3_g", 32'(last_grant), 32'h01);
`endif

        // OP2 not ready for 3 cycles: select held, no grant, then granted.
        do_reset();
        g_dest[3] = 2; g_tail[3] = 1'b1; g_ready[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step("bp");
            check("bp_sel", 32'(last_sel[2]), 32'h08);
            check("bp_g", 32'(last_grant), 32'h00);
        end
        g_ready[2] = 1'b1;
        step("bp_go"); check("bp_go_g", 32'(last_grant), 32'h08);

        // All inputs to distinct outputs: every input granted at once.
        clear_inputs();
        for (int i = 0; i < NP; i++) g_dest[i] = (i + 1) % NP;
        g_tail = '1;
        step("all"); check("all_g", 32'(last_grant), 32'h1f);

        // Mid-packet reset of OP0 owned by P2; P4 then wins immediately.
        clear_inputs();
        g_dest[2] = 0;
        step("mr_h");
        do_reset();
        g_dest[4] = 0; g_tail[4] = 1'b1;
        step("mr_p4"); check("mr_p4_g", 32'(last_grant), 32'h10);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++)
                g_dest[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, NP-1));
            g_tail  = NP'($urandom);
            g_ready = NP'($urandom | $urandom);
            g_rstn  = ($urandom_range(0, 49) != 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
